// File: rtl/rev_counter_seq.sv
// Sequencer for a W-bit up/down counter: latches a target, sets the counter direction
// and issues paced single-cycle step enables until the counter reaches the target.
module rev_counter_seq #(
    parameter int unsigned W   = 4,
    parameter int unsigned DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] target,
    input  logic         pause,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cnt_dir,
    output logic         cnt_step,
    input  logic [W-1:0] cnt_q,
    input  logic         cnt_rc
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PresLast = PW'(DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  target_q, target_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          dir_q, dir_d;
    logic          step_q, step_d;
    logic [W-1:0]  cnt_next;
    logic          landing;

    // A step issued last cycle has not reached cnt_q yet; with DIV=1 this stops a
    // second back-to-back step from overshooting the target.
    assign cnt_next = dir_q ? cnt_q + W'(1) : cnt_q - W'(1);
    assign landing  = step_q && (cnt_next == target_q);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        target_d = target_q;
        err_d    = err_q;
        dir_d    = dir_q;
        step_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    target_d = target;
                    err_d    = 1'b0;
                    presc_d  = '0;
                    if (target == cnt_q) begin
                        state_d = StDone;
                    end else begin
                        dir_d   = (target > cnt_q);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_q == target_q) begin
                    state_d = StDone;
                end else if (pause) begin
                    state_d = StHold;
                end else if (presc_q == PresLast) begin
                    presc_d = '0;
                    if (landing) begin
                        step_d = 1'b0;
                    end else if (cnt_rc) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        step_d = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StHold: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            target_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            target_q <= target_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cnt_dir  = dir_q;
    assign cnt_step = step_q;

endmodule

// File: tb/tb_rev_counter_seq.sv
// Directed bench for rev_counter_seq (W=4, DIV=4) with a behavioural up/down counter
// closing the loop on cnt_step/cnt_dir.
module tb_rev_counter_seq;

    logic       clk = 1'b0;
    logic       rst, start, pause, abort;
    logic [3:0] target;
    logic       busy, done, err, cnt_dir, cnt_step;
    logic [3:0] cnt_q;
    logic       cnt_rc;
    logic       set_en, force_rc;
    logic [3:0] set_val;
    logic [3:0] exp_target;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_step = 0;
    int n_done = 0;
    int n_over = 0;
    int step_at [64];
    int s0, d0, c0, bg, lim;

    always #5 clk = ~clk;

    rev_counter_seq #(.W(4), .DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .target   (target),
        .pause    (pause),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cnt_dir  (cnt_dir),
        .cnt_step (cnt_step),
        .cnt_q    (cnt_q),
        .cnt_rc   (cnt_rc)
    );

    // Counter datapath model
    always @(posedge clk) begin
        if (set_en) cnt_q <= set_val;
        else if (cnt_step) cnt_q <= cnt_dir ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
    assign cnt_rc = force_rc | (cnt_dir ? (cnt_q == 4'd15) : (cnt_q == 4'd0));

    // Event monitor
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_step === 1'b1) begin
            step_at[n_step % 64] <= cyc;
            n_step <= n_step + 1;
            if (cnt_q == exp_target) n_over <= n_over + 1;
        end
        if (done === 1'b1) n_done <= n_done + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic set_cnt(input logic [3:0] v);
        set_en  = 1'b1;
        set_val = v;
        tick();
        set_en  = 1'b0;
    endtask

    task automatic go(input logic [3:0] t);
        start      = 1'b1;
        target     = t;
        exp_target = t;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i;
        i = 0;
        while (done !== 1'b1 && i < 200) begin
            tick();
            i++;
        end
        chk(tag, done, 1);
    endtask

    task automatic wait_steps(input int base, input int n, input string tag);
        int i;
        i = 0;
        while (n_step - base < n && i < 200) begin
            tick();
            i++;
        end
        chk(tag, n_step - base, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; target = '0;
        set_en = 1'b1; set_val = '0; force_rc = 1'b0; exp_target = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_step", cnt_step, 0);
        chk("rst_dir", cnt_dir, 0);
        rst = 1'b0;
        set_en = 1'b0;

        // 1: count up 0 -> 9
        set_cnt(4'd0);
        s0 = n_step; d0 = n_done;
        go(4'd9);
        c0 = cyc;
        chk("t1_busy", busy, 1);
        chk("t1_dir", cnt_dir, 1);
        chk("t1_nodone", done, 0);
        wait_done("t1_done");
        chk("t1_cnt", cnt_q, 9);
        chk("t1_steps", n_step - s0, 9);
        chk("t1_first", step_at[s0 % 64] - c0, 4);
        bg = 0;
        for (int i = 1; i < 9; i++)
            if (step_at[(s0 + i) % 64] - step_at[(s0 + i - 1) % 64] != 4) bg++;
        chk("t1_gaps", bg, 0);
        chk("t1_done_lat", cyc - step_at[(s0 + 8) % 64], 2);
        chk("t1_busy_done", busy, 1);
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_busy_off", busy, 0);
        chk("t1_ndone", n_done - d0, 1);

        // 2: count down 9 -> 3
        s0 = n_step; d0 = n_done;
        go(4'd3);
        chk("t2_dir", cnt_dir, 0);
        wait_done("t2_done");
        chk("t2_cnt", cnt_q, 3);
        chk("t2_steps", n_step - s0, 6);
        tick();
        chk("t2_ndone", n_done - d0, 1);

        // 3: already at target
        set_cnt(4'd5);
        s0 = n_step;
        go(4'd5);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 1);
        tick();
        chk("t3_done_off", done, 0);
        chk("t3_busy_off", busy, 0);
        chk("t3_err", err, 0);
        chk("t3_steps", n_step - s0, 0);

        // 4: pause after 2nd step of 0 -> 7
        set_cnt(4'd0);
        s0 = n_step;
        go(4'd7);
        wait_steps(s0, 2, "t4_two");
        pause = 1'b1;
        repeat (10) tick();
        chk("t4_frozen", n_step - s0, 2);
        chk("t4_busy", busy, 1);
        pause = 1'b0;
        wait_done("t4_done");
        chk("t4_steps", n_step - s0, 7);
        chk("t4_gap_pause", step_at[(s0 + 2) % 64] - step_at[(s0 + 1) % 64], 15);
        chk("t4_gap_after", step_at[(s0 + 3) % 64] - step_at[(s0 + 2) % 64], 4);
        chk("t4_cnt", cnt_q, 7);
        tick();

        // 5: abort after 3rd step of 0 -> 12, then reset mid-run, then 3 -> 1
        set_cnt(4'd0);
        s0 = n_step; d0 = n_done;
        go(4'd12);
        wait_steps(s0, 3, "t5_three");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_step", cnt_step, 0);
        repeat (2) tick();
        chk("t5_cnt", cnt_q, 3);
        chk("t5_nodone", n_done - d0, 0);
        chk("t5_steps", n_step - s0, 3);
        go(4'd10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_dir", cnt_dir, 0);
        chk("t5_rst_cnt", cnt_q, 3);
        s0 = n_step;
        abort = 1'b1;
        go(4'd1);
        abort = 1'b0;
        chk("t5_startabort_busy", busy, 1);
        chk("t5_new_dir", cnt_dir, 0);
        wait_done("t5_new_done");
        chk("t5_new_cnt", cnt_q, 1);
        chk("t5_new_steps", n_step - s0, 2);
        tick();

        // 6: forced ripple carry at the step point
        set_cnt(4'd2);
        s0 = n_step;
        go(4'd10);
        force_rc = 1'b1;
        lim = 0;
        while (err !== 1'b1 && lim < 20) begin
            tick();
            lim++;
        end
        chk("t6_err", err, 1);
        chk("t6_busy", busy, 0);
        chk("t6_steps", n_step - s0, 0);
        chk("t6_cnt", cnt_q, 2);
        force_rc = 1'b0;
        repeat (3) tick();
        chk("t6_sticky", err, 1);
        go(4'd4);
        chk("t6_err_clr", err, 0);
        chk("t6_busy2", busy, 1);
        wait_done("t6_done");
        chk("t6_cnt2", cnt_q, 4);
        tick();

        chk("overshoot", n_over, 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
